// File: rtl/branch_target_predictor_if.sv
// branch_target_predictor_if: fetch lookup, execute resolve and perf-counter signals of the BTB.
//   master: pipeline side (drives PCF and the Execute resolve fields, reads predictions/redirect/counters)
//   slave : predictor side
interface branch_target_predictor_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] PCF;
  logic PredTakenF;
  logic [XLEN-1:0] PredTargetF;
  logic ResolveE;
  logic FlushE;
  logic [XLEN-1:0] PCE;
  logic IsJumpE;
  logic TakenE;
  logic [XLEN-1:0] TargetE;
  logic PredTakenE;
  logic [XLEN-1:0] PredTargetE;
  logic MispredictE;
  logic [XLEN-1:0] RedirectPCE;
  logic InvalidateAll;
  logic [31:0] BranchCount;
  logic [31:0] MispredictCount;
  modport master (
    output PCF, ResolveE, FlushE, PCE, IsJumpE, TakenE, TargetE, PredTakenE, PredTargetE, InvalidateAll,
    input PredTakenF, PredTargetF, MispredictE, RedirectPCE, BranchCount, MispredictCount
  );
  modport slave (
    input PCF, ResolveE, FlushE, PCE, IsJumpE, TakenE, TargetE, PredTakenE, PredTargetE, InvalidateAll,
    output PredTakenF, PredTargetF, MispredictE, RedirectPCE, BranchCount, MispredictCount
  );
endinterface

// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB with saturating direction counters beside the fetch PC.
//   clk, reset : clock and asynchronous active-high reset
//   bus.PCF -> PredTakenF/PredTargetF : combinational fetch lookup
//   bus.ResolveE/FlushE/PCE/IsJumpE/TakenE/TargetE/PredTakenE/PredTargetE : Execute resolve
//   bus.MispredictE/RedirectPCE : combinational redirect decision
//   bus.InvalidateAll : synchronous clear of all valid bits (fence.i)
//   bus.BranchCount/MispredictCount : wrapping performance counters
module branch_target_predictor #(
  parameter int XLEN = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_BITS = 2
) (
  input logic clk,
  input logic reset,
  branch_target_predictor_if.slave bus
);
  localparam int IDX = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] WEAK_T = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] WEAK_NT = WEAK_T - CTR_BITS'(1);
  logic validQ [ENTRIES];
  logic [TAGW-1:0] tagQ [ENTRIES];
  logic [XLEN-1:0] targetQ [ENTRIES];
  logic jumpQ [ENTRIES];
  logic [CTR_BITS-1:0] ctrQ [ENTRIES];
  logic [31:0] branchCount;
  logic [31:0] mispredictCount;
  logic [IDX-1:0] idxF;
  logic [IDX-1:0] idxE;
  logic [TAGW-1:0] tagE;
  logic hitF;
  logic hitE;
  logic predTakenF;
  logic active;
  logic update;
  logic mispredict;
  logic [CTR_BITS-1:0] ctrNext;
  logic unusedPcBits;
  assign idxF = bus.PCF[IDX+1:2];
  assign idxE = bus.PCE[IDX+1:2];
  assign tagE = bus.PCE[XLEN-1:IDX+2];
  assign hitF = validQ[idxF] && tagQ[idxF] == bus.PCF[XLEN-1:IDX+2];
  assign hitE = validQ[idxE] && tagQ[idxE] == tagE;
  assign predTakenF = hitF && (jumpQ[idxF] || ctrQ[idxF][CTR_BITS-1]);
  assign bus.PredTakenF = predTakenF;
  assign bus.PredTargetF = predTakenF ? targetQ[idxF] : '0;
  assign active = bus.ResolveE && !bus.FlushE;
  // A not-taken miss leaves the entry alone; anything else writes the indexed slot.
  assign update = active && !bus.InvalidateAll && (hitE || bus.TakenE);
  // Fresh allocations start weakly taken; hits move one step and saturate.
  assign ctrNext = !hitE ? WEAK_T
                 : bus.TakenE ? (ctrQ[idxE] == CTR_MAX ? CTR_MAX : ctrQ[idxE] + CTR_BITS'(1))
                 : (ctrQ[idxE] == '0 ? '0 : ctrQ[idxE] - CTR_BITS'(1));
  assign mispredict = active && ((bus.TakenE != bus.PredTakenE) || (bus.TakenE && bus.TargetE != bus.PredTargetE));
  assign bus.MispredictE = mispredict;
  assign bus.RedirectPCE = bus.TakenE ? bus.TargetE : bus.PCE + XLEN'(4);
  assign bus.BranchCount = branchCount;
  assign bus.MispredictCount = mispredictCount;
  assign unusedPcBits = ^{bus.PCF[1:0], bus.PCE[1:0]};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validQ[i] <= 1'b0;
        tagQ[i] <= '0;
        targetQ[i] <= '0;
        jumpQ[i] <= 1'b0;
        ctrQ[i] <= WEAK_NT;
      end
      branchCount <= '0;
      mispredictCount <= '0;
    end else begin
      if (bus.InvalidateAll) begin
        for (int i = 0; i < ENTRIES; i++) validQ[i] <= 1'b0;
      end else if (update) begin
        validQ[idxE] <= 1'b1;
        tagQ[idxE] <= tagE;
        ctrQ[idxE] <= ctrNext;
        if (bus.TakenE) begin
          targetQ[idxE] <= bus.TargetE;
          jumpQ[idxE] <= bus.IsJumpE;
        end
      end
      if (active) branchCount <= branchCount + 32'd1;
      if (mispredict) mispredictCount <= mispredictCount + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: scoreboard bench for the BTB (ENTRIES=16, CTR_BITS=2, XLEN=32).
module tb_branch_target_predictor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  branch_target_predictor_if #(.XLEN(32)) bus ();
  branch_target_predictor #(.XLEN(32), .ENTRIES(16), .CTR_BITS(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  int cmps = 0;
  int errs = 0;
  logic [31:0] expQ [$];
  logic [31:0] e;
  logic [31:0] bCnt = 0;
  logic [31:0] mCnt = 0;
  task automatic idle;
    bus.ResolveE = 0; bus.FlushE = 0; bus.InvalidateAll = 0; bus.PCE = 0; bus.IsJumpE = 0;
    bus.TakenE = 0; bus.TargetE = 0; bus.PredTakenE = 0; bus.PredTargetE = 0;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic resolve(input logic [31:0] pc, input logic taken, input logic jump, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptg, input logic flush, input logic inv);
    logic mis;
    bus.ResolveE = 1; bus.FlushE = flush; bus.InvalidateAll = inv; bus.PCE = pc; bus.IsJumpE = jump;
    bus.TakenE = taken; bus.TargetE = tgt; bus.PredTakenE = pt; bus.PredTargetE = ptg;
    mis = !flush && ((taken != pt) || (taken && tgt != ptg));
    expQ.push_back({31'b0, mis});
    expQ.push_back(taken ? tgt : pc + 32'd4);
    if (!flush) bCnt++;
    if (mis) mCnt++;
  endtask
  task automatic lookup(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    bus.PCF = pc;
    expQ.push_back({31'b0, taken});
    expQ.push_back(taken ? tgt : 32'h0);
  endtask
  task automatic test_reset;
    idle;
    lookup(32'h100, 0, 0);
    resolve(32'h100, 1, 0, 32'h80, 0, 0, 0, 0);
    #1;
    e = expQ.pop_front(); cmps++; if (bus.PredTakenF !== e[0]) begin errs++; $display("FAIL reset_predtaken got %b want %b", bus.PredTakenF, e[0]); end
    e = expQ.pop_front(); cmps++; if (bus.PredTargetF !== e) begin errs++; $display("FAIL reset_predtarget got %h want %h", bus.PredTargetF, e); end
    e = expQ.pop_front(); cmps++; if (bus.MispredictE !== e[0]) begin errs++; $display("FAIL reset_mispredict got %b want %b", bus.MispredictE, e[0]); end
    e = expQ.pop_front(); cmps++; if (bus.RedirectPCE !== e) begin errs++; $display("FAIL reset_redirect got %h want %h", bus.RedirectPCE, e); end
    tick;
    bCnt = 0; mCnt = 0;
    lookup(32'h100, 0, 0);
    expQ.push_back(bCnt);
    expQ.push_back(mCnt);
    #1;
    e = expQ.pop_front(); cmps++; if (bus.PredTakenF !== e[0]) begin errs++; $display("FAIL reset_hold_predtaken got %b want %b", bus.PredTakenF, e[0]); end
    e = expQ.pop_front(); cmps++; if (bus.PredTargetF !== e) begin errs++; $display("FAIL reset_hold_predtarget got %h want %h", bus.PredTargetF, e); end
    e = expQ.pop_front(); cmps++; if (bus.BranchCount !== e) begin errs++; $display("FAIL reset_branchcount got %0d want %0d", bus.BranchCount, e); end
    e = expQ.pop_front(); cmps++; if (bus.MispredictCount !== e) begin errs++; $display("FAIL reset_mispredictcount got %0d want %0d", bus.MispredictCount, e); end
    idle;
    @(negedge clk);
    reset = 0;
    tick;
    resolve(32'h100, 0, 0, 32'h80, 0, 0, 0, 0);
    #1;
    e = expQ.pop_front(); cmps++; if (bus.MispredictE !== e[0]) begin errs++; $display("FAIL nt_mispredict got %b want %b", bus.MispredictE, e[0]); end
    e = expQ.pop_front(); cmps++; if (bus.RedirectPCE !== e) begin errs++; $display("FAIL nt_redirect got %h want %h", bus.RedirectPCE, e); end
    tick;
    idle;
    lookup(32'h100, 0, 0);
    #1;
    e = expQ.pop_front(); cmps++; if (bus.PredTakenF !== e[0]) begin errs++; $display("FAIL nt_noalloc_predtaken got %b want %b", bus.PredTakenF, e[0]); end
    e = expQ.pop_front(); cmps++; if (bus.PredTargetF !== e) begin errs++; $display("FAIL nt_noalloc_predtarget got %h want %h", bus.PredTargetF, e); end
  endtask
  task automatic test_allocation;
    resolve(32'h100, 1, 0, 32'h80, 0, 0, 0, 0);
    lookup(32'h100, 0, 0);
    #1;
    e = expQ.pop_front(); cmps++; if (bus.MispredictE !== e[0]) begin errs++; $display("FAIL alloc_mispredict got %b want %b", bus.MispredictE, e[0]); end
    e = expQ.pop_front(); cmps++; if (bus.RedirectPCE !== e) begin errs++; $display("FAIL alloc_redirect got %h want %h", bus.RedirectPCE, e); end
    e = expQ.pop_front(); cmps++; if (bus.PredTakenF !== e[0]) begin errs++; $display("FAIL alloc_sameCycle_predtaken got %b want %b", bus.PredTakenF, e[0]); end
    e = expQ.pop_front(); cmps++; if (bus.PredTargetF !== e) begin errs++; $display("FAIL alloc_sameCycle_predtarget got %h want %h", bus.PredTargetF, e); end
    tick;
    idle;
    lookup(32'h100, 1, 32'h80);
    expQ.push_back(mCnt);
    #1;
    e = expQ.pop_front(); cmps++; if (bus.PredTakenF !== e[0]) begin errs++; $display("FAIL alloc_predtaken got %b want %b", bus.PredTakenF, e[0]); end
    e = expQ.pop_front(); cmps++; if (bus.PredTargetF !== e) begin errs++; $display("FAIL alloc_predtarget got %h want %h", bus.PredTargetF, e); end
    e = expQ.pop_front(); cmps++; if (bus.MispredictCount !== e) begin errs++; $display("FAIL alloc_mispredictcount got %0d want %0d", bus.MispredictCount, e); end
  endtask
  task automatic test_saturation;
    logic outcomes [9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
    int c = 2;
    logic pred;
    for (int i = 0; i < 9; i++) begin
      pred = c >= 2;
      resolve(32'h100, outcomes[i], 0, 32'h80, pred, pred ? 32'h80 : 32'h0, 0, 0);
      #1;
      e = expQ.pop_front(); cmps++; if (bus.MispredictE !== e[0]) begin errs++; $display("FAIL sat%0d_mispredict got %b want %b", i, bus.MispredictE, e[0]); end
      e = expQ.pop_front(); cmps++; if (bus.RedirectPCE !== e) begin errs++; $display("FAIL sat%0d_redirect got %h want %h", i, bus.RedirectPCE, e); end
      tick;
      idle;
      c = outcomes[i] ? (c == 3 ? 3 : c + 1) : (c == 0 ? 0 : c - 1);
      lookup(32'h100, c >= 2, 32'h80);
      #1;
      e = expQ.pop_front(); cmps++; if (bus.PredTakenF !== e[0]) begin errs++; $display("FAIL sat%0d_predtaken got %b want %b", i, bus.PredTakenF, e[0]); end
      e = expQ.pop_front(); cmps++; if (bus.PredTargetF !== e) begin errs++; $display("FAIL sat%0d_predtarget got %h want %h", i, bus.PredTargetF, e); end
    end
  endtask
  task automatic test_alias_jump;
    resolve(32'h140, 1, 1, 32'h300, 0, 0, 0, 0);
    tick;
    idle;
    expQ.pop_front(); expQ.pop_front();
    lookup(32'h140, 1, 32'h300);
    #1;
    e = expQ.pop_front(); cmps++; if (bus.PredTakenF !== e[0]) begin errs++; $display("FAIL alias_new_predtaken got %b want %b", bus.PredTakenF, e[0]); end
    e = expQ.pop_front(); cmps++; if (bus.PredTargetF !== e) begin errs++; $display("FAIL alias_new_predtarget got %h want %h", bus.PredTargetF, e); end
    lookup(32'h100, 0, 0);
    #1;
    e = expQ.pop_front(); cmps++; if (bus.PredTakenF !== e[0]) begin errs++; $display("FAIL alias_old_predtaken got %b want %b", bus.PredTakenF, e[0]); end
    e = expQ.pop_front(); cmps++; if (bus.PredTargetF !== e) begin errs++; $display("FAIL alias_old_predtarget got %h want %h", bus.PredTargetF, e); end
    // Drive the counter to 0 with not-taken resolves; the jump flag must still force taken.
    for (int i = 0; i < 2; i++) begin
      resolve(32'h140, 0, 0, 32'h0, 1, 32'h300, 0, 0);
      #1;
      e = expQ.pop_front(); cmps++; if (bus.MispredictE !== e[0]) begin errs++; $display("FAIL jump%0d_mispredict got %b want %b", i, bus.MispredictE, e[0]); end
      e = expQ.pop_front(); cmps++; if (bus.RedirectPCE !== e) begin errs++; $display("FAIL jump%0d_redirect got %h want %h", i, bus.RedirectPCE, e); end
      tick;
    end
    idle;
    lookup(32'h140, 1, 32'h300);
    #1;
    e = expQ.pop_front(); cmps++; if (bus.PredTakenF !== e[0]) begin errs++; $display("FAIL jump_flag_predtaken got %b want %b", bus.PredTakenF, e[0]); end
    e = expQ.pop_front(); cmps++; if (bus.PredTargetF !== e) begin errs++; $display("FAIL jump_flag_predtarget got %h want %h", bus.PredTargetF, e); end
  endtask
  task automatic test_simultaneous;
    resolve(32'h200, 1, 0, 32'h400, 0, 0, 0, 1);
    lookup(32'h140, 1, 32'h300);
    #1;
    e = expQ.pop_front(); cmps++; if (bus.MispredictE !== e[0]) begin errs++; $display("FAIL inv_mispredict got %b want %b", bus.MispredictE, e[0]); end
    e = expQ.pop_front(); cmps++; if (bus.RedirectPCE !== e) begin errs++; $display("FAIL inv_redirect got %h want %h", bus.RedirectPCE, e); end
    e = expQ.pop_front(); cmps++; if (bus.PredTakenF !== e[0]) begin errs++; $display("FAIL inv_sameCycle_predtaken got %b want %b", bus.PredTakenF, e[0]); end
    e = expQ.pop_front(); cmps++; if (bus.PredTargetF !== e) begin errs++; $display("FAIL inv_sameCycle_predtarget got %h want %h", bus.PredTargetF, e); end
    tick;
    idle;
    lookup(32'h200, 0, 0);
    #1;
    e = expQ.pop_front(); cmps++; if (bus.PredTakenF !== e[0]) begin errs++; $display("FAIL inv_noalloc_predtaken got %b want %b", bus.PredTakenF, e[0]); end
    e = expQ.pop_front(); cmps++; if (bus.PredTargetF !== e) begin errs++; $display("FAIL inv_noalloc_predtarget got %h want %h", bus.PredTargetF, e); end
    lookup(32'h140, 0, 0);
    #1;
    e = expQ.pop_front(); cmps++; if (bus.PredTakenF !== e[0]) begin errs++; $display("FAIL inv_cleared_predtaken got %b want %b", bus.PredTakenF, e[0]); end
    e = expQ.pop_front(); cmps++; if (bus.PredTargetF !== e) begin errs++; $display("FAIL inv_cleared_predtarget got %h want %h", bus.PredTargetF, e); end
    resolve(32'h200, 1, 0, 32'h400, 0, 0, 0, 0);
    lookup(32'h200, 0, 0);
    #1;
    expQ.pop_front(); expQ.pop_front();
    e = expQ.pop_front(); cmps++; if (bus.PredTakenF !== e[0]) begin errs++; $display("FAIL nobypass_predtaken got %b want %b", bus.PredTakenF, e[0]); end
    e = expQ.pop_front(); cmps++; if (bus.PredTargetF !== e) begin errs++; $display("FAIL nobypass_predtarget got %h want %h", bus.PredTargetF, e); end
    tick;
    resolve(32'h200, 0, 0, 32'h0, 1, 32'h400, 1, 0);
    lookup(32'h200, 1, 32'h400);
    #1;
    e = expQ.pop_front(); cmps++; if (bus.MispredictE !== e[0]) begin errs++; $display("FAIL flush_mispredict got %b want %b", bus.MispredictE, e[0]); end
    expQ.pop_front();
    e = expQ.pop_front(); cmps++; if (bus.PredTakenF !== e[0]) begin errs++; $display("FAIL fresh_predtaken got %b want %b", bus.PredTakenF, e[0]); end
    e = expQ.pop_front(); cmps++; if (bus.PredTargetF !== e) begin errs++; $display("FAIL fresh_predtarget got %h want %h", bus.PredTargetF, e); end
    tick;
    idle;
    lookup(32'h200, 1, 32'h400);
    expQ.push_back(bCnt);
    expQ.push_back(mCnt);
    #1;
    e = expQ.pop_front(); cmps++; if (bus.PredTakenF !== e[0]) begin errs++; $display("FAIL flush_noupdate_predtaken got %b want %b", bus.PredTakenF, e[0]); end
    e = expQ.pop_front(); cmps++; if (bus.PredTargetF !== e) begin errs++; $display("FAIL flush_noupdate_predtarget got %h want %h", bus.PredTargetF, e); end
    e = expQ.pop_front(); cmps++; if (bus.BranchCount !== e) begin errs++; $display("FAIL flush_branchcount got %0d want %0d", bus.BranchCount, e); end
    e = expQ.pop_front(); cmps++; if (bus.MispredictCount !== e) begin errs++; $display("FAIL flush_mispredictcount got %0d want %0d", bus.MispredictCount, e); end
  endtask
  task automatic test_wrap;
    resolve(32'hFFFFFFFC, 0, 0, 32'h0, 0, 0, 0, 0);
    #1;
    e = expQ.pop_front(); cmps++; if (bus.MispredictE !== e[0]) begin errs++; $display("FAIL wrap_mispredict got %b want %b", bus.MispredictE, e[0]); end
    e = expQ.pop_front(); cmps++; if (bus.RedirectPCE !== e) begin errs++; $display("FAIL wrap_redirect got %h want %h", bus.RedirectPCE, e); end
    tick;
    idle;
    force dut.branchCount = 32'hFFFFFFFF;
    #1;
    release dut.branchCount;
    bCnt = 32'hFFFFFFFF;
    resolve(32'h300, 0, 0, 32'h0, 0, 0, 0, 0);
    #1;
    expQ.pop_front(); expQ.pop_front();
    tick;
    idle;
    expQ.push_back(bCnt);
    expQ.push_back(mCnt);
    #1;
    e = expQ.pop_front(); cmps++; if (bus.BranchCount !== e) begin errs++; $display("FAIL wrap_branchcount got %h want %h", bus.BranchCount, e); end
    e = expQ.pop_front(); cmps++; if (bus.MispredictCount !== e) begin errs++; $display("FAIL wrap_mispredictcount got %0d want %0d", bus.MispredictCount, e); end
  endtask
  initial begin
    bus.PCF = 0;
    test_reset;
    test_allocation;
    test_saturation;
    test_alias_jump;
    test_simultaneous;
    test_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout compared %0d", cmps);
    $fatal(1, "timeout");
  end
endmodule
